// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flags
// Brief    : Single-clock FIFO with occupancy count, status flags, error
//            pulses and selectable registered-read / first-word-fall-through.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_flags #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_rq,
  input  logic                     rd_rq,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_PW = c_AW + 1;
  localparam logic [c_AW:0] c_DEPTH = c_PW'(DEPTH);
  localparam logic [c_AW:0] c_AF    = c_PW'(AF_THRESH);
  localparam logic [c_AW:0] c_AE    = c_PW'(AE_THRESH);
  localparam logic [c_AW:0] c_ONE   = c_PW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [c_AW-1:0]  w_wr_addr;
  logic [c_AW-1:0]  w_rd_addr;

  assign w_full    = (r_count == c_DEPTH);
  assign w_empty   = (r_count == '0);
  // Flush wins over both requests, so neither side is accepted that cycle.
  assign w_wr_acc  = wr_rq & ~w_full  & ~flush;
  assign w_rd_acc  = rd_rq & ~w_empty & ~flush;
  assign w_wr_addr = r_wr_ptr[c_AW-1:0];
  assign w_rd_addr = r_rd_ptr[c_AW-1:0];

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= c_AF);
  assign almost_empty = (r_count <= c_AE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  always_ff @(posedge clk_in) begin
    if (w_wr_acc) begin
      r_mem[w_wr_addr] <= wdata;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_rq & w_full;
      r_underflow <= rd_rq & w_empty;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_ONE;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is visible as soon as it exists; nothing stale when empty.
      assign rdata = w_empty ? '0 : r_mem[w_rd_addr];
    end else begin : g_reg_read
      logic [WIDTH-1:0] r_rdata;

      always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
          r_rdata <= '0;
        end else if (flush) begin
          r_rdata <= '0;
        end else if (w_rd_acc) begin
          r_rdata <= r_mem[w_rd_addr];
        end
      end

      assign rdata = r_rdata;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-003 SHALL have parameter AF_THRESH, default 6, almost_full threshold (1..DEPTH).
REQ-004 SHALL have parameter AE_THRESH, default 2, almost_empty threshold (0..DEPTH-1).
REQ-005 SHALL have parameter FWFT, default 0, 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL have port clk_in  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port flush  input  1  synchronous clear of contents.
REQ-009 SHALL have port wr_rq  input  1  write request.
REQ-010 SHALL have port rd_rq  input  1  read request.
REQ-011 SHALL have port wdata  input  WIDTH  write data.
REQ-012 SHALL have port rdata  output  WIDTH  read data.
REQ-013 SHALL have port full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have port overflow, underflow  output  1 each  single-cycle error pulses.

Function
REQ-016 Write SHALL be accepted iff wr_rq=1 and full=0; accepted write stores wdata at write address, write pointer +1.
REQ-017 Read SHALL be accepted iff rd_rq=1 and empty=0; accepted read advances read pointer +1.
REQ-018 Pointers SHALL be $clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; address = low $clog2(DEPTH) bits.
REQ-019 count SHALL be a register: +1 on write-only accept, -1 on read-only accept, unchanged when both or neither accepted.
REQ-020 Flags SHALL be combinational from count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_THRESH), almost_empty = (count<=AE_THRESH).
REQ-021 Simultaneous wr_rq and rd_rq while full: read accepted, write rejected (no pass-through).
REQ-022 Simultaneous wr_rq and rd_rq while empty: write accepted, read rejected.
REQ-023 Simultaneous accepted write and read at any other occupancy: both performed, count unchanged.
REQ-024 FWFT=0: rdata SHALL be registered, updated one cycle after an accepted read with the entry at the pre-increment read address; held otherwise.
REQ-025 FWFT=1: rdata SHALL show the head entry combinationally whenever empty=0, 0 when empty=1; an accepted read exposes the next entry in the following cycle.
REQ-026 overflow SHALL pulse high for exactly the cycle after a rejected write (wr_rq=1, full=1); storage and pointers unchanged.
REQ-027 underflow SHALL pulse high for exactly the cycle after a rejected read (rd_rq=1, empty=1); rdata unchanged.
REQ-028 flush=1 SHALL, at the clock edge, zero both pointers and count, and zero rdata, with priority over wr_rq/rd_rq; no overflow/underflow from that cycle.
REQ-029 Data SHALL emerge in strict write order across any number of pointer wrap-arounds.

Reset
REQ-030 rst=1 SHALL immediately, without a clock, zero pointers, count, rdata, overflow, underflow; hence empty=1, almost_empty=1, full=0, almost_full=0.
REQ-031 Storage array contents need not be reset; no read SHALL return a value not written since last reset/flush.
REQ-032 Reset asserted mid-operation SHALL discard all contents and any in-flight accept; first edge after release behaves as from empty.

Verification (defaults: WIDTH=4, DEPTH=8, AF=6, AE=2)
REQ-033 Fill: write 1..8 -> count 1..8; almost_empty drops at count 3; almost_full rises at count 6; full at 8; 9th write -> overflow pulse 1 cycle, count stays 8.
REQ-034 Drain (FWFT=0): read 8 times -> rdata 1..8 each one cycle after read; empty after 8th; 9th read -> underflow pulse, rdata holds 8.
REQ-035 Simultaneous: count=4, wr_rq=rd_rq=1 for 10 cycles -> count stays 4, order preserved; at full -> only read taken, count 7; at empty -> only write taken, count 1.
REQ-036 Wrap: 20 interleaved write/read pairs of 0..F repeating -> every value returned in order, no spurious flags.
REQ-037 FWFT=1: write A -> rdata=A next cycle with no read; write B, read -> rdata=B next cycle; read -> rdata=0, empty=1.
REQ-038 Reset/flush: count=5, assert rst between edges -> count 0, empty=1 immediately; repeat with flush plus wr_rq -> count 0, write ignored.
